// File: rtl/reg_read_port_pkg.sv
// Shared constants, pending-write entry type and helpers for the register read port.
package reg_read_port_pkg;

    localparam int unsigned NREGS    = 32;
    localparam int unsigned WIDTH    = 64;
    localparam int unsigned WR_LAT   = 3;
    localparam int unsigned AW       = 5;
    localparam int unsigned ZERO_REG = 31;

    // One in-flight write that the bank has not yet committed.
    typedef struct packed {
        logic             vld;
        logic [AW-1:0]    rg;
        logic [WIDTH-1:0] data;
    } pend_entry_t;

    // Index 31 is hard-wired to zero and never takes writes.
    function automatic logic is_zero_reg(input logic [AW-1:0] r);
        return r == AW'(ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_read_port_if.sv
// Read request / read result handshake bundle between consumer and the read port.
interface reg_read_port_if
    import reg_read_port_pkg::*;
#(
    parameter int unsigned WIDTH = reg_read_port_pkg::WIDTH
);

    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    // Consumer side: issues reads and takes results.
    modport master (
        output rd_valid,
        output rd_addr_a,
        output rd_addr_b,
        output out_ready,
        input  rd_ready,
        input  out_valid,
        input  out_a,
        input  out_b
    );

    // Read port side.
    modport slave (
        input  rd_valid,
        input  rd_addr_a,
        input  rd_addr_b,
        input  out_ready,
        output rd_ready,
        output out_valid,
        output out_a,
        output out_b
    );

endinterface

// File: rtl/reg_read_port_wr_pend_pipe.sv
// Pending-write shift pipeline with two priority-forwarding lookup ports.
module wr_pend_pipe
    import reg_read_port_pkg::*;
#(
    parameter int unsigned NREGS  = reg_read_port_pkg::NREGS,
    parameter int unsigned WIDTH  = reg_read_port_pkg::WIDTH,
    parameter int unsigned WR_LAT = reg_read_port_pkg::WR_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] regs_in [NREGS],
    input  logic [AW-1:0]    lk_addr_a,
    input  logic [AW-1:0]    lk_addr_b,
    output logic [WIDTH-1:0] lk_data_a_c,
    output logic [WIDTH-1:0] lk_data_b_c
);

    logic [WR_LAT-1:0] r_vld;
    logic [AW-1:0]     r_reg  [WR_LAT];
    logic [WIDTH-1:0]  r_data [WR_LAT];

    logic [AW-1:0]     w_addr [2];
    logic [WIDTH-1:0]  w_data [2];

    assign w_addr[0]   = lk_addr_a;
    assign w_addr[1]   = lk_addr_b;
    assign lk_data_a_c = w_data[0];
    assign lk_data_b_c = w_data[1];

    // Shift the in-flight writes one slot per edge; the oldest falls off as the bank commits it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < int'(WR_LAT); i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= wr_en && !is_zero_reg(wr_reg);
            r_reg[0]  <= wr_reg;
            r_data[0] <= wr_data;
            for (int i = 1; i < int'(WR_LAT); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_reg[i]  <= r_reg[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Per port: bank value, overridden oldest-to-newest by pending entries, then by the live write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_data[p] = '0;
            if (!is_zero_reg(w_addr[p])) begin
                if (32'(w_addr[p]) < NREGS) begin
                    w_data[p] = regs_in[w_addr[p]];
                end
                for (int i = int'(WR_LAT) - 1; i >= 0; i--) begin
                    if (r_vld[i] && (r_reg[i] == w_addr[p])) begin
                        w_data[p] = r_data[i];
                    end
                end
                if (wr_en && (wr_reg == w_addr[p])) begin
                    w_data[p] = wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Dual register read port with write forwarding and a single registered result slot.
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int unsigned NREGS  = reg_read_port_pkg::NREGS,
    parameter int unsigned WIDTH  = reg_read_port_pkg::WIDTH,
    parameter int unsigned WR_LAT = reg_read_port_pkg::WR_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] regs_in [NREGS],
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    reg_read_port_if.slave   bus
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;

    logic             w_accept;
    logic [WIDTH-1:0] w_data_a;
    logic [WIDTH-1:0] w_data_b;

    // Slot frees up in the same cycle the consumer drains it.
    assign bus.rd_ready  = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.rd_valid && bus.rd_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;

    wr_pend_pipe #(
        .NREGS  (NREGS),
        .WIDTH  (WIDTH),
        .WR_LAT (WR_LAT)
    ) u_pend (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .regs_in     (regs_in),
        .lk_addr_a   (bus.rd_addr_a),
        .lk_addr_b   (bus.rd_addr_b),
        .lk_data_a_c (w_data_a),
        .lk_data_b_c (w_data_b)
    );

    // Result slot: load on acceptance, clear on drain, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_data_a;
            r_out_b     <= w_data_b;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench: architectural-state reference model against the read port.
module tb_reg_read_port;
    import reg_read_port_pkg::*;

    localparam int unsigned NR  = 32;
    localparam int unsigned W   = 64;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic         v;
        logic [4:0]   r;
        logic [W-1:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_reg;
    logic [W-1:0] wr_data;
    logic [W-1:0] regs_in [NR];

    reg_read_port_if #(.WIDTH(W)) bus ();

    reg_read_port #(
        .NREGS  (NR),
        .WIDTH  (W),
        .WR_LAT (LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .regs_in (regs_in),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: arch holds every write as soon as it is sampled; the bank (regs_in)
    // only sees a write LAT edges later, via the pq delay queue.
    logic [W-1:0] arch [NR];
    wr_t          pq [$];
    bit           m_valid;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           n_pass;
    int           n_total;

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input bit v, input logic [4:0] a, input logic [4:0] b, input bit ordy,
                         input bit we, input logic [4:0] wr, input logic [W-1:0] wd);
        bus.rd_valid  = v;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        bus.out_ready = ordy;
        wr_en         = we;
        wr_reg        = wr;
        wr_data       = wd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
    endtask

    task automatic set_bank(input logic [4:0] r, input logic [W-1:0] v);
        regs_in[r] = v;
        arch[r]    = v;
    endtask

    task automatic model_reset();
        pq.delete();
        m_valid = 1'b0;
        arch    = regs_in;
    endtask

    // One clock: check ready, advance model and bank, check registered outputs.
    task automatic tick(input string tag);
        logic [W-1:0] nxt [NR];
        bit           acc;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        wr_t          e;
        #1;
        n_total++;
        if (bus.rd_ready !== (!m_valid || bus.out_ready))
            $display("FAIL %s rd_ready: got %b expected %b", tag, bus.rd_ready, !m_valid || bus.out_ready);
        else n_pass++;
        acc = bus.rd_valid && (!m_valid || bus.out_ready);
        nxt = arch;
        if (wr_en && wr_reg != 5'd31) nxt[wr_reg] = wr_data;
        ea = (bus.rd_addr_a == 5'd31) ? '0 : nxt[bus.rd_addr_a];
        eb = (bus.rd_addr_b == 5'd31) ? '0 : nxt[bus.rd_addr_b];
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_a     = ea;
            m_b     = eb;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        arch = nxt;
        e.v = wr_en && (wr_reg != 5'd31);
        e.r = wr_reg;
        e.d = wr_data;
        pq.push_back(e);
        while (pq.size() > LAT) begin
            e = pq.pop_front();
            if (e.v) regs_in[e.r] = e.d;
        end
        n_total++;
        if (bus.out_valid !== m_valid)
            $display("FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, m_valid);
        else n_pass++;
        if (m_valid) begin
            n_total++;
            if (bus.out_a !== m_a) $display("FAIL %s out_a: got %h expected %h", tag, bus.out_a, m_a);
            else n_pass++;
            n_total++;
            if (bus.out_b !== m_b) $display("FAIL %s out_b: got %h expected %h", tag, bus.out_b, m_b);
            else n_pass++;
        end
    endtask

    task automatic flush();
        idle();
        for (int i = 0; i < int'(LAT) + 1; i++) tick("flush");
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_a !== '0 || bus.out_b !== '0 || bus.rd_ready !== 1'b1)
            $display("FAIL %s: got valid=%b a=%h b=%h ready=%b expected 0/0/0/1", tag,
                     bus.out_valid, bus.out_a, bus.out_b, bus.rd_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        for (int i = 0; i < int'(NR); i++) regs_in[i] = rnd64();
        #2;
        check_reset_outputs("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        model_reset();
        reset = 1'b1;
    endtask

    // First read right after reset: bank value on port a, zero register on port b.
    task automatic test_basic();
        set_bank(5'd5, 64'h11);
        set_bank(5'd31, 64'hDEAD_BEEF);
        drive(1'b1, 5'd5, 5'd31, 1'b1, 1'b0, 5'd0, '0);
        tick("basic");
        n_total++;
        if (bus.out_a !== 64'h11 || bus.out_b !== '0 || bus.out_valid !== 1'b1)
            $display("FAIL basic_const: got a=%h b=%h v=%b expected 11/0/1", bus.out_a, bus.out_b, bus.out_valid);
        else n_pass++;
    endtask

    // Forwarding window: live input, then each pending slot, then committed bank.
    task automatic test_forward_window();
        flush();
        set_bank(5'd7, '0);
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 64'hFF);
        for (int k = 0; k < 5; k++) begin
            tick("fwd");
            n_total++;
            if (bus.out_a !== 64'hFF) $display("FAIL fwd_%0d: got %h expected ff", k, bus.out_a);
            else n_pass++;
            drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, '0);
        end
    endtask

    task automatic test_newest_wins();
        flush();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 64'hA);
        tick("newest_w1");
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 64'hB);
        tick("newest_w2");
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, '0);
        tick("newest_rd");
        n_total++;
        if (bus.out_a !== 64'hB || bus.out_b !== 64'hB)
            $display("FAIL newest: got a=%h b=%h expected b/b", bus.out_a, bus.out_b);
        else n_pass++;
    endtask

    task automatic test_stall();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, '0);
        tick("stall_load");
        drive(1'b1, 5'd4, 5'd6, 1'b0, 1'b0, 5'd0, '0);
        for (int k = 0; k < 4; k++) begin
            tick("stall_hold");
            n_total++;
            if (bus.rd_ready !== 1'b0) $display("FAIL stall_ready: got %b expected 0", bus.rd_ready);
            else n_pass++;
        end
        drive(1'b1, 5'd4, 5'd6, 1'b1, 1'b0, 5'd0, '0);
        tick("stall_release");
        idle();
        tick("stall_drain");
    endtask

    task automatic test_zero_reg();
        flush();
        set_bank(5'd31, 64'h5A5A);
        drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 64'h5);
        for (int k = 0; k < 4; k++) begin
            tick("zero");
            n_total++;
            if (bus.out_a !== '0 || bus.out_b !== '0)
                $display("FAIL zero_%0d: got a=%h b=%h expected 0/0", k, bus.out_a, bus.out_b);
            else n_pass++;
            drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b0, 5'd0, '0);
        end
    endtask

    task automatic test_reset_mid();
        flush();
        set_bank(5'd2, 64'h9);
        drive(1'b1, 5'd2, 5'd2, 1'b0, 1'b1, 5'd2, 64'h55);
        tick("rmid_load");
        idle();
        reset = 1'b0;
        #1;
        check_reset_outputs("rmid_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rmid_held");
        model_reset();
        reset = 1'b1;
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        tick("rmid_read");
        n_total++;
        if (bus.out_a !== 64'h9) $display("FAIL rmid_value: got %h expected 9", bus.out_a);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] wr;
        for (int k = 0; k < 500; k++) begin
            a  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            b  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            wr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, wr, rnd64());
            tick("random");
        end
        idle();
        tick("random_end");
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
        test_reset();
        test_basic();
        test_forward_window();
        test_newest_wins();
        test_stall();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
